// File: rtl/sr_drv_pkg.sv
// Shared types and defaults for the SR latch driver.
package sr_drv_pkg;

  localparam int DEF_PULSE_CYCLES   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_CHECK = 2'd2
  } sr_state_e;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-stage synchronizer, async active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives Set/Reset pulses into an external SR latch and confirms Q readback.
// Optional: SR_SKIP_REDUNDANT_EN completes a command at once when Q already matches.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic CmdValid,
  input  logic CmdSet,
  output logic CmdReady,
  output logic Set,
  output logic Reset,
  input  logic QIn,
  output logic Busy,
  output logic Done,
  output logic Err
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  sr_state_e        state_q, state_d;
  logic             target_q, target_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             set_q, set_d;
  logic             reset_q, reset_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             q_sync;
  logic             accept;

  sync_2ff u_q_sync (
    .clk   (Clk),
    .rst_n (ResetN),
    .d     (QIn),
    .q     (q_sync)
  );

  assign accept = CmdValid & ready_q;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pcnt_d   = pcnt_q;
    tcnt_d   = tcnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          target_d = CmdSet;
`ifdef SR_SKIP_REDUNDANT_EN
          if (q_sync == CmdSet) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_PULSE;
            pcnt_d  = PULSE_LOAD;
          end
`else
          state_d = ST_PULSE;
          pcnt_d  = PULSE_LOAD;
`endif
        end
      end
      ST_PULSE: begin
        if (pcnt_q == '0) begin
          state_d = ST_CHECK;
          tcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      ST_CHECK: begin
        if (q_sync == target_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tcnt_q >= TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so Set/Reset are exclusive by construction.
    set_d   = (state_d == ST_PULSE) &  target_d;
    reset_d = (state_d == ST_PULSE) & ~target_d;
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= ST_IDLE;
      target_q <= 1'b0;
      pcnt_q   <= '0;
      tcnt_q   <= '0;
      set_q    <= 1'b0;
      reset_q  <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pcnt_q   <= pcnt_d;
      tcnt_q   <= tcnt_d;
      set_q    <= set_d;
      reset_q  <= reset_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign CmdReady = ready_q;
  assign Set      = set_q;
  assign Reset    = reset_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign Busy     = (state_q != ST_IDLE);

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Clocked initiator that drives Set/Reset pulses into an external SR latch and reads back its Q output to confirm each command.
- Accepts a valid/ready set-or-clear command, emits a fixed-width, non-overlapping Set or Reset pulse, then waits for the synchronized Q readback.
- Reports Done when Q reaches the target level, or Err on timeout.
- Sits between control logic and any latch-style storage element in the lab designs.

Parameters:
- PULSE_CYCLES, 4, width of the Set/Reset pulse in clock cycles (>=1).
- TIMEOUT_CYCLES, 16, cycles spent in CHECK without a match before Err (>=1).
- CNT_W, 8, counter width; must hold max(PULSE_CYCLES, TIMEOUT_CYCLES).

Ports:
- Clk  input  1  system clock, rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- CmdValid  input  1  command request.
- CmdSet  input  1  command type: 1 = set latch, 0 = reset latch; sampled on accept.
- CmdReady  output  1  block can accept a command (IDLE only).
- Set  output  1  registered Set drive to the latch.
- Reset  output  1  registered Reset drive to the latch.
- QIn  input  1  latch Q readback, asynchronous to Clk.
- Busy  output  1  high in PULSE or CHECK.
- Done  output  1  one-cycle pulse: command confirmed.
- Err  output  1  one-cycle pulse: command timed out.

Behaviour:
- Reset (ResetN low, async):
  - Set = Reset = Done = Err = Busy = 0; CmdReady = 0.
  - Synchronizer flops = 0; counters = 0; state = IDLE.
  - CmdReady rises on the first clock edge after ResetN deasserts.
  - Reset mid-command aborts immediately; no Done or Err is produced.
- States: IDLE, PULSE, CHECK.
- IDLE:
  - CmdReady = 1.
  - Accept on the edge where CmdValid & CmdReady. Capture target = CmdSet, load pulse counter = PULSE_CYCLES-1, go to PULSE.
- PULSE:
  - Set = target, Reset = ~target, both registered.
  - Asserted from cycle acc+1 through acc+PULSE_CYCLES inclusive.
  - Set and Reset are never high in the same cycle, under any condition.
  - When the counter reaches 0, drop both outputs and go to CHECK with the timeout counter cleared.
- CHECK:
  - Compare QSync against target each cycle. QSync is QIn through a 2-flop synchronizer.
  - Match: next cycle Done = 1 and state = IDLE (CmdReady = 1 in that same cycle).
  - No match for TIMEOUT_CYCLES consecutive CHECK cycles: next cycle Err = 1 and state = IDLE.
  - Done and Err are mutually exclusive and each lasts exactly one cycle.
- CmdValid while not in IDLE is ignored. The command is not queued; the requester must hold CmdValid until accepted.
- Back-to-back operation: a command may be accepted in the same cycle Done/Err is high. Minimum command period = PULSE_CYCLES + 2 cycles.
- Counters saturate; they never wrap.
- Busy = (state != IDLE).

Optional Feature:
- Macro: SR_SKIP_REDUNDANT_EN.
- Defined:
  - On accept, if QSync already equals CmdSet, skip PULSE and CHECK.
  - Set/Reset stay low; Done pulses at acc+1; return to IDLE.
- Undefined: every accepted command produces a full pulse and check.

Decomposition:
- Package sr_drv_pkg:
  - State enum (IDLE/PULSE/CHECK).
  - Default PULSE_CYCLES / TIMEOUT_CYCLES localparams.
- Sub-module sync_2ff: 1-bit, 2-stage synchronizer with async active-low reset to 0. Instantiated once for QIn.

Test Plan:
- Bench latch model: Q follows Set/Reset combinationally; P=4, T=16; accept at cycle 0.
- Set command:
  - Stimulus: CmdSet=1 accepted at cycle 0.
  - Response: Set=1 cycles 1-4, Reset=0 throughout; Done=1 at cycle 6 only; CmdReady=1 at cycle 6; Err never.
- Reset after set:
  - Stimulus: CmdSet=0 issued right after the previous test.
  - Response: Reset=1 for exactly 4 cycles, Set=0; Done 6 cycles after accept; model Q=0.
- Stuck latch:
  - Stimulus: QIn tied 0, CmdSet=1 at cycle 0.
  - Response: Set pulse cycles 1-4; CHECK cycles 5-20; Err=1 at cycle 21 only; Done never.
- Mid-command reset:
  - Stimulus: ResetN=0 at cycle 2 of a set pulse.
  - Response: Set falls asynchronously; no Done/Err; CmdReady=1 one edge after ResetN=1.
- Busy ignore:
  - Stimulus: CmdValid held high with toggling CmdSet during PULSE/CHECK.
  - Response: no extra pulses; the next command is accepted only when CmdReady=1; Set&Reset never both 1 (assertion over whole run).
- SR_SKIP_REDUNDANT_EN:
  - Stimulus: latch already set, CmdSet=1.
  - Response: no Set pulse; Done at cycle 1.
